// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one split-transaction read at a time,
// buffers one word under decode stall and flushes on branch/jump redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | just out of reset, request starts next cycle
// REQ     | imem_req high, waiting for grant
// WAIT    | request granted, waiting for the response
// DISCARD | granted request was flushed, drop its response when it arrives
// FULL    | one word buffered while decode stalls
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instruction,
  output logic [31:0] IF_pc_register
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, FULL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  assign target    = redirect_target & 32'hFFFF_FFFC;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc & 32'hFFFF_FFFC;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      buf_instr      <= 32'h0;
      buf_pc4        <= 32'h0;
      IF_instruction <= 32'h0;
      IF_pc_register <= 32'h0;
    end else begin
      // Non-delivering cycles: bubble unless decode is stalled; a redirect always flushes.
      if (!stall || redirect_valid)
        IF_instruction <= 32'h0;

      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_gnt) state <= DISCARD;
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (redirect_valid) begin
              pc    <= target;
              state <= REQ;
            end else if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc4   <= pc_plus4;
              pc        <= pc_plus4;
              state     <= FULL;
            end else begin
              IF_instruction <= imem_rdata;
              IF_pc_register <= pc_plus4;
              pc             <= pc_plus4;
              state          <= REQ;
            end
          end else if (redirect_valid) begin
            pc    <= target;
            state <= DISCARD;
          end
        end

        DISCARD: begin
          if (redirect_valid) pc <= target;
          if (imem_rvalid) state <= REQ;
        end

        FULL: begin
          if (redirect_valid) begin
            buf_instr <= 32'h0;
            buf_pc4   <= 32'h0;
            pc        <= target;
            state     <= REQ;
          end else if (!stall) begin
            IF_instruction <= buf_instr;
            IF_pc_register <= buf_pc4;
            state          <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with a latency-varying
// memory responder and a second instance exercising PC wrap-around from reset.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, IF_instruction, IF_pc_register;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_instruction(IF_instruction), .IF_pc_register(IF_pc_register)
  );

  // Second instance: reset PC near the top of the address space, free-running memory.
  logic        w_rst_n, w_req, w_rvalid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset_n(w_rst_n), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .IF_instruction(w_instr), .IF_pc_register(w_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder (driven from the stimulus thread) ----------
  bit          pending = 0, acc = 0;
  logic [31:0] paddr = 0, acc_addr = 0;
  int          cnt = 0, acc_delay = 1;

  task automatic mem_pre();
    if (imem_rvalid) pending = 0;
    if (acc) begin
      pending = 1;
      paddr   = acc_addr;
      cnt     = acc_delay;
    end
    acc = 0;
    if (pending && cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = paddr ^ 32'hA5A5_0000;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pending) cnt--;
    end
  endtask

  // Called at a negedge; drives one cycle and returns at the following negedge.
  task automatic step(input logic s, input logic r, input logic [31:0] t,
                      input logic g, input int d);
    stall           = s;
    redirect_valid  = r;
    redirect_target = t;
    imem_gnt        = g;
    acc       = imem_req && g;
    acc_addr  = imem_addr;
    acc_delay = d;
    @(posedge clock);
    @(negedge clock);
    mem_pre();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    pending        = 0;
    acc            = 0;
    imem_rvalid    = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    #1;
    check("async_reset_instr", IF_instruction, 32'h0);
    check("async_reset_pc", IF_pc_register, 32'h0);
    check("async_reset_req", {31'b0, imem_req}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
  endtask

  // ---------------- reference model: what the fetch stream must look like ------
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } item_t;
  item_t       q[$];
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] out_addr = 32'h0;
  bit          out_live = 0;
  bit          m_valid = 0, m_deliver = 0, m_redirect = 0, m_stall = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      q.delete();
      out_live = 0;
      exp_pc   = 32'h0;
      m_valid  = 0;
    end else begin
      // A word is handed over whenever decode accepts and one is available.
      m_deliver  = !redirect_valid && !stall && ((q.size() > 0) || (imem_rvalid && out_live));
      m_redirect = redirect_valid;
      m_stall    = stall;
      m_valid    = 1;
      if (imem_rvalid) begin
        if (out_live && !redirect_valid) begin
          q.push_back('{instr: imem_rdata, pc4: out_addr + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
        out_live = 0;
      end
      if (acc) begin
        check("req_addr", acc_addr, exp_pc);
        out_addr = acc_addr;
        out_live = 1;
      end
      if (redirect_valid) begin
        q.delete();
        out_live = 0;
        exp_pc   = redirect_target & 32'hFFFF_FFFC;
      end
    end
  end

  // ---------------- monitor ----------------------------------------------------
  logic [31:0] prev_i = 0, prev_p = 0;

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      check("reset_instr", IF_instruction, 32'h0);
      check("reset_pc", IF_pc_register, 32'h0);
      prev_i = 0;
      prev_p = 0;
    end else if (m_valid) begin
      bit    delivered;
      item_t it;
      delivered = ((IF_instruction != prev_i) || (IF_pc_register != prev_p)) && (IF_instruction != 0);
      check("deliver_timing", {31'b0, delivered}, {31'b0, m_deliver});
      if (delivered || m_deliver) begin
        if (q.size() == 0) fail_now("scoreboard_underflow");
        else begin
          it = q.pop_front();
          if (delivered) begin
            check("instr", IF_instruction, it.instr);
            check("pc_register", IF_pc_register, it.pc4);
          end
        end
      end else if (m_redirect || !m_stall) begin
        check("bubble_instr", IF_instruction, 32'h0);
        check("bubble_pc", IF_pc_register, prev_p);
      end else begin
        check("hold_instr", IF_instruction, prev_i);
        check("hold_pc", IF_pc_register, prev_p);
      end
      prev_i = IF_instruction;
      prev_p = IF_pc_register;
    end
  end

  // ---------------- wrap instance: memory and checks ----------------------------
  logic [31:0] w_exp_addr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] w_exp_pc   [2] = '{32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] w_exp_ins  [2] = '{32'h5A5A_FFF8, 32'h5A5A_FFFC};
  bit          w_pend = 0;
  logic [31:0] w_paddr = 0, w_prev = 0;
  int          w_g = 0, w_n = 0;

  always @(negedge clock) begin
    if (!w_rst_n) begin
      w_pend   = 0;
      w_rvalid = 1'b0;
      w_rdata  = 32'h0;
    end else begin
      w_rvalid = w_pend;
      w_rdata  = w_paddr ^ 32'hA5A5_0000;
      w_pend   = w_req;
      if (w_req) begin
        if (w_g < 3) check("wrap_req_addr", w_addr, w_exp_addr[w_g]);
        w_g++;
        w_paddr = w_addr;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (w_rst_n && w_instr != w_prev && w_instr != 0) begin
      if (w_n < 2) begin
        check("wrap_pc_register", w_pc, w_exp_pc[w_n]);
        check("wrap_instr", w_instr, w_exp_ins[w_n]);
      end
      w_n++;
    end
    w_prev = w_instr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ---------------------------------------------------
  initial begin
    int k;
    logic [31:0] a;
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; w_rst_n = 1'b0;
    #23 w_rst_n = 1'b1;
    @(negedge clock);
    do_reset();

    // First request in the second clock after release, then free-run.
    step(0, 0, 32'h0, 1, 1);
    check("first_req", {31'b0, imem_req}, 32'h1);

    // Stall three cycles starting on the response cycle for address 8.
    k = 0;
    while (!(imem_rvalid && paddr == 32'h8) && k < 50) begin step(0, 0, 32'h0, 1, 1); k++; end
    if (k >= 50) fail_now("timeout_addr8");
    repeat (3) begin
      step(1, 0, 32'h0, 1, 1);
      check("full_no_req", {31'b0, imem_req}, 32'h0);
    end
    step(0, 0, 32'h0, 1, 1);
    check("resume_req", {31'b0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h0000_000C);

    // Redirect while waiting; the stale response arrives two cycles later.
    step(0, 0, 32'h0, 1, 3);
    step(0, 1, 32'h0000_0100, 1, 1);
    k = 0;
    while (!imem_req && k < 20) begin step(0, 0, 32'h0, 0, 1); k++; end
    check("redirect_req_addr", imem_addr, 32'h0000_0100);
    k = 0;
    while (IF_instruction == 0 && k < 20) begin step(0, 0, 32'h0, 1, 1); k++; end
    check("redirect_pc_register", IF_pc_register, 32'h0000_0104);

    // Redirect coincident with a response under stall.
    k = 0;
    while (!imem_rvalid && k < 20) begin step(0, 0, 32'h0, 1, 1); k++; end
    if (k >= 20) fail_now("timeout_rvalid");
    step(1, 1, 32'h0000_0200, 1, 1);
    check("flush_instr", IF_instruction, 32'h0);
    check("flush_req", {31'b0, imem_req}, 32'h1);
    check("flush_addr", imem_addr, 32'h0000_0200);

    // Grant withheld for five cycles.
    a = imem_addr;
    repeat (5) begin
      step(0, 0, 32'h0, 0, 1);
      check("nogrant_req", {31'b0, imem_req}, 32'h1);
      check("nogrant_addr", imem_addr, a);
    end

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 32'h0000_FFFF), $urandom_range(0, 3) != 0,
           $urandom_range(1, 3));
    end
    repeat (20) step(0, 0, 32'h0, 1, 1);
    check("scoreboard_empty", q.size(), 32'h0);
    check("wrap_deliveries_seen", {31'b0, w_n >= 2}, 32'h1);
    check("wrap_requests_seen", {31'b0, w_g >= 3}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
